wb_regfile: RTL

- Consumer end of the MEM/WB pipeline boundary: writeback stage plus architectural register file.
- Takes the latched ALU result, memory word, destination register, writeback-source select and write-enable from MEM/WB.
- Selects the writeback value and commits it to a 32x32 register file.
- Serves two read ports to the ID stage, with same-cycle write-to-read bypass so no extra hazard stall is needed for a WB/ID overlap.

---
 rtl/wb_regfile.sv | 75 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry architectural register file.
// Selects the MEM/WB result, commits it, and serves two bypassed read ports.
module wb_regfile #(
   parameter int                DATA_W  = 32,
   parameter int                ADDR_W  = 5,
   parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_3FFC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ALU_res_in,
   input  logic [DATA_W-1:0] mem_word_in,
   input  logic [ADDR_W-1:0] rs_rt_in,
   input  logic              wb_src_in,
   input  logic              wb_write_in,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_valid
);

   localparam int NREG   = 2 ** ADDR_W;
   localparam int SP_IDX = 29;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   wr_en;
   logic              byp1;
   logic              byp2;

   assign wb_data  = wb_src_in ? mem_word_in : ALU_res_in;
   assign wb_valid = wb_write_in && (rs_rt_in != '0);

   // Gating on wb_valid keeps an unknown index from reaching storage
   always_comb begin
      wr_en = '0;
      for (int i = 1; i < NREG; i++) begin
         if (wb_valid && (rs_rt_in == ADDR_W'(i))) begin
            wr_en[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (wr_en[i]) begin
               regs[i] <= wb_data;
            end
         end
      end
   end

   assign byp1 = wb_valid && (rd_addr1 == rs_rt_in);
   assign byp2 = wb_valid && (rd_addr2 == rs_rt_in);

   always_comb begin
      rd_data1 = '0;
      if (rd_addr1 != '0) begin
         rd_data1 = byp1 ? wb_data : regs[rd_addr1];
      end
   end

   always_comb begin
      rd_data2 = '0;
      if (rd_addr2 != '0) begin
         rd_data2 = byp2 ? wb_data : regs[rd_addr2];
      end
   end

endmodule
